// File: rtl/nt_bus_pkg.sv
`default_nettype none
// ============================================================================
// nt_bus_pkg : shared sizes, FSM encoding and helpers for the 8-way arbiter
// Rev 1.0
// ============================================================================
package nt_bus_pkg;

  localparam int N_PORTS = 8;
  localparam int SEL_W   = 3;
  localparam int CNT_W   = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  function automatic logic [N_PORTS-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N_PORTS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux8way16_arbiter_if.sv
`default_nettype none
// ============================================================================
// mux8way16_arbiter_if : request/select/handshake bundle between sources,
// arbiter and consumer.  Rev 1.0
// ============================================================================
interface mux8way16_arbiter_if;
  import nt_bus_pkg::*;

  logic [N_PORTS-1:0] req;
  logic [N_PORTS-1:0] last;
  logic               out_ready;
  logic [SEL_W-1:0]   sel;
  logic [N_PORTS-1:0] grant;
  logic               out_valid;
  logic               out_last;
  logic [N_PORTS-1:0] ack;

  // Arbiter side
  modport master (
    input  req, last, out_ready,
    output sel, grant, out_valid, out_last, ack
  );

  // Source/consumer side
  modport slave (
    output req, last, out_ready,
    input  sel, grant, out_valid, out_last, ack
  );

endinterface
`default_nettype wire

// File: rtl/rr_pick8.sv
`default_nettype none
// ============================================================================
// rr_pick8 : first set request at or after ptr, wrapping modulo 8.
// Rev 1.0
// ============================================================================
module rr_pick8
  import nt_bus_pkg::*;
(
  input  logic [N_PORTS-1:0] req_i,
  input  logic [SEL_W-1:0]   ptr_i,
  output logic               any_o,
  output logic [SEL_W-1:0]   idx_o
);

  logic [SEL_W-1:0] cand;

  // Scan from the farthest offset down so the nearest hit overwrites the rest.
  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    cand  = '0;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      cand = ptr_i + SEL_W'(k);
      if (req_i[cand]) begin
        any_o = 1'b1;
        idx_o = cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mux8way16_arbiter.sv
`default_nettype none
// ============================================================================
// mux8way16_arbiter : round-robin owner select for a shared 16-bit 8-way mux
// with packet hold and a per-grant word limit.  Rev 1.0
// ============================================================================
module mux8way16_arbiter
  import nt_bus_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
)
(
  input  logic                clk,
  input  logic                reset,
  mux8way16_arbiter_if.master bus
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q,   sel_d;
  logic [SEL_W-1:0]   ptr_q,   ptr_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [N_PORTS-1:0] grant_q, grant_d;

  logic               busy;
  logic               owner_req;
  logic               xfer;
  logic               release_now;
  logic [SEL_W-1:0]   after_owner;
  logic [SEL_W-1:0]   pick_ptr;
  logic               pick_any;
  logic [SEL_W-1:0]   pick_idx;

  assign busy        = (state_q == ST_BUSY);
  assign owner_req   = bus.req[sel_q];
  assign xfer        = busy & owner_req & bus.out_ready;
  assign release_now = xfer & (bus.last[sel_q] | (cnt_q == HOLD_LAST));
  assign after_owner = sel_q + 1'b1;

  // While busy the only pick that matters is the release re-arbitration,
  // which starts just past the owner so it falls to lowest priority.
  assign pick_ptr = busy ? after_owner : ptr_q;

  rr_pick8 u_pick (
    .req_i (bus.req),
    .ptr_i (pick_ptr),
    .any_o (pick_any),
    .idx_o (pick_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    unique case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        if (pick_any) begin
          state_d = ST_BUSY;
          sel_d   = pick_idx;
          grant_d = onehot(pick_idx);
          cnt_d   = '0;
        end
      end
      ST_BUSY: begin
        if (!owner_req) begin
          state_d = ST_IDLE;
          ptr_d   = after_owner;
          grant_d = '0;
          cnt_d   = '0;
        end else if (xfer) begin
          cnt_d = cnt_q + 1'b1;
          if (release_now) begin
            ptr_d = after_owner;
            if (pick_any) begin
              sel_d   = pick_idx;
              grant_d = onehot(pick_idx);
              cnt_d   = '0;
            end else begin
              state_d = ST_IDLE;
              grant_d = '0;
              cnt_d   = '0;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  assign bus.sel       = sel_q;
  assign bus.grant     = grant_q;
  assign bus.out_valid = busy & owner_req;
  assign bus.out_last  = bus.out_valid & bus.last[sel_q];
  assign bus.ack       = grant_q & {N_PORTS{bus.out_valid & bus.out_ready}};

endmodule
`default_nettype wire

// File: tb/tb_mux8way16_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mux8way16_arbiter : directed scenarios plus randomized traffic against a
// behavioural round-robin model.  Rev 1.0
// ============================================================================
module tb_mux8way16_arbiter;
  import nt_bus_pkg::*;

  localparam int MAX_HOLD = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  bit   chk_en = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;

  mux8way16_arbiter_if bus ();

  mux8way16_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_ptr   = 0;
  int m_words = 0;   // words already moved under the current grant

  function automatic int pick(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++)
      if (r[(p + k) % 8]) return (p + k) % 8;
    return -1;
  endfunction

  always @(posedge clk or posedge reset) begin : model
    int p;
    if (reset) begin
      m_busy  <= 1'b0;
      m_owner <= 0;
      m_ptr   <= 0;
      m_words <= 0;
    end else if (!m_busy) begin
      p = pick(bus.req, m_ptr);
      if (p >= 0) begin
        m_busy  <= 1'b1;
        m_owner <= p;
        m_words <= 0;
      end
    end else if (!bus.req[m_owner]) begin
      m_busy <= 1'b0;
      m_ptr  <= (m_owner + 1) % 8;
    end else if (bus.out_ready) begin
      if (bus.last[m_owner] || (m_words + 1 == MAX_HOLD)) begin
        m_ptr <= (m_owner + 1) % 8;
        p = pick(bus.req, (m_owner + 1) % 8);
        if (p >= 0) begin
          m_owner <= p;
          m_words <= 0;
        end else begin
          m_busy <= 1'b0;
        end
      end else begin
        m_words <= m_words + 1;
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin : compare
    logic [7:0] eg;
    logic       ev;
    if (chk_en) begin
      eg = m_busy ? (8'd1 << m_owner) : 8'd0;
      ev = m_busy && bus.req[m_owner];
      check("m_grant",     bus.grant,     eg);
      check("m_sel",       8'(bus.sel),   8'(m_owner));
      check("m_out_valid", 8'(bus.out_valid), 8'(ev));
      check("m_out_last",  8'(bus.out_last),  8'(ev && bus.last[m_owner]));
      check("m_ack",       bus.ack,       (ev && bus.out_ready) ? eg : 8'd0);
    end
  end

  // Inputs change 1 after the edge; literal checks land 3 after the edge.
  task automatic drive(input logic [7:0] r, input logic [7:0] l, input logic o);
    @(posedge clk);
    #1;
    bus.req       = r;
    bus.last      = l;
    bus.out_ready = o;
    #2;
  endtask

  initial begin
    logic [7:0] r;
    logic [7:0] l;
    bus.req       = '0;
    bus.last      = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant", bus.grant, 8'h00);
    check("rst_sel",   8'(bus.sel), 8'h00);
    check("rst_valid", 8'(bus.out_valid), 8'h00);
    check("rst_ack",   bus.ack, 8'h00);
    reset  = 1'b0;
    chk_en = 1'b1;

    // Single requester 3, two-word packet
    drive(8'h08, 8'h00, 1'b1); check("A_idle", bus.grant, 8'h00);
    drive(8'h08, 8'h00, 1'b1); check("A_g1", bus.grant, 8'h08); check("A_ack1", bus.ack, 8'h08);
    drive(8'h08, 8'h08, 1'b1); check("A_ack2", bus.ack, 8'h08); check("A_last", 8'(bus.out_last), 8'h01);
    drive(8'h00, 8'h00, 1'b1); check("A_hold", bus.grant, 8'h08); check("A_noack", bus.ack, 8'h00);
    drive(8'h00, 8'h00, 1'b1); check("A_idle2", bus.grant, 8'h00);

    // All requesting, single-word packets: rotate with no bubble (ptr is 4)
    drive(8'hFF, 8'hFF, 1'b1); check("B_idle", bus.grant, 8'h00);
    for (int k = 0; k < 9; k++) begin
      drive(8'hFF, 8'hFF, 1'b1);
      check("B_sel", 8'(bus.sel), 8'((4 + k) % 8));
      check("B_ack", bus.ack, 8'd1 << ((4 + k) % 8));
    end
    drive(8'h00, 8'h00, 1'b1); check("B_next", bus.grant, 8'h20);
    drive(8'h00, 8'h00, 1'b1); check("B_idle2", bus.grant, 8'h00);

    // Requester 5 streams 6 words, split at the word limit by requester 2
    drive(8'h20, 8'h00, 1'b1); check("C_idle", bus.grant, 8'h00);
    for (int k = 0; k < 4; k++) begin
      drive(8'h24, 8'h00, 1'b1); check("C_ack5", bus.ack, 8'h20);
    end
    drive(8'h24, 8'h04, 1'b1); check("C_g2", bus.grant, 8'h04); check("C_ack2", bus.ack, 8'h04);
    drive(8'h20, 8'h00, 1'b1); check("C_re5", bus.ack, 8'h20);
    drive(8'h20, 8'h20, 1'b1); check("C_w6", bus.ack, 8'h20); check("C_last", 8'(bus.out_last), 8'h01);
    drive(8'h00, 8'h00, 1'b1); check("C_hold", bus.grant, 8'h20);
    drive(8'h00, 8'h00, 1'b1); check("C_idle2", bus.grant, 8'h00);

    // Owner 1 stalled by the consumer while everyone requests
    drive(8'h02, 8'h00, 1'b0); check("D_idle", bus.grant, 8'h00);
    for (int k = 0; k < 10; k++) begin
      drive(8'hFF, 8'h00, 1'b0);
      check("D_grant", bus.grant, 8'h02);
      check("D_ack0", bus.ack, 8'h00);
    end
    drive(8'hFF, 8'h00, 1'b1); check("D_ack", bus.ack, 8'h02);
    drive(8'h00, 8'h00, 1'b0); check("D_hold", bus.grant, 8'h02);
    drive(8'h00, 8'h00, 1'b0); check("D_idle2", bus.grant, 8'h00);

    // Owner 6 abandons; wrapped pointer 7 favours requester 0 over 6
    drive(8'h40, 8'h00, 1'b1); check("E_idle", bus.grant, 8'h00);
    drive(8'h40, 8'h00, 1'b1); check("E_ack", bus.ack, 8'h40);
    drive(8'h00, 8'h00, 1'b1); check("E_hold", bus.grant, 8'h40);
    drive(8'h41, 8'h00, 1'b1); check("E_idle2", bus.grant, 8'h00);
    drive(8'h00, 8'h00, 1'b1); check("E_g0", bus.grant, 8'h01);
    drive(8'h00, 8'h00, 1'b1); check("E_idle3", bus.grant, 8'h00);

    // Asynchronous reset while requester 5 is mid-packet
    drive(8'h20, 8'h00, 1'b1); check("F_idle", bus.grant, 8'h00);
    drive(8'h20, 8'h00, 1'b1); check("F_ack1", bus.ack, 8'h20);
    drive(8'h20, 8'h00, 1'b1); check("F_ack2", bus.ack, 8'h20);
    drive(8'h20, 8'h00, 1'b0); check("F_busy", bus.grant, 8'h20);
    reset = 1'b1;
    #1;
    check("F_rst_grant", bus.grant, 8'h00);
    check("F_rst_valid", 8'(bus.out_valid), 8'h00);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #2;
    check("F_post_idle", bus.grant, 8'h00);
    drive(8'h20, 8'h00, 1'b1); check("F_regrant", bus.grant, 8'h20);

    // Randomized traffic with sticky requests and occasional resets
    r = 8'h20;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 8; i++)
        if ($urandom_range(7) == 0) r[i] = ~r[i];
      l = 8'($urandom) & 8'($urandom);
      drive(r, l, $urandom_range(3) != 0);
      if ($urandom_range(499) == 0) begin
        reset = 1'b1;
        #1;
        check("R_rst_grant", bus.grant, 8'h00);
        @(posedge clk);
        #1;
        reset = 1'b0;
      end
    end

    @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mux8way16_arbiter.md
# mux8way16_arbiter

Round-robin arbiter that shares one 16-bit 8-way word multiplexer among eight requesters feeding a single consumer. The arbiter drives the mux's 3-bit select and a one-hot grant, and gates a valid/ready handshake toward the consumer. Packets of one or more words are supported, and a per-grant word limit guarantees fairness. It sits between the eight source ports and the shared Mux8Way16 data path. The data words themselves never pass through this block.

## Interface
- MAX_HOLD, 4: maximum words transferred per grant before forced release; legal range 1..16.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  8  per-requester "word available"; bit i corresponds to mux input i (a=0 … h=7).
- last  in  8  per-requester "current word ends packet"; sampled only for the owner.
- out_ready  in  1  consumer accepts the word on the mux output this cycle.
- sel  out  3  select to Mux8Way16; equals owner index.
- grant  out  8  one-hot owner, or all-zero when idle; registered.
- out_valid  out  1  mux output holds a valid word; equals busy & req[sel].
- out_last  out  1  out_valid & last[sel].
- ack  out  8  grant & {8{out_valid & out_ready}}; the word is consumed this cycle.

## Operation
- State: IDLE/BUSY (1 bit), owner sel[2:0], rr pointer ptr[2:0], word counter cnt[3:0].
- Pick function: first i in order ptr, ptr+1, …, ptr+7 (mod 8) with req[i]=1.
- IDLE:
  - grant=0 and out_valid=0.
  - If any req is set, load sel=pick, set grant=onehot(pick), clear cnt, and go to BUSY.
- BUSY, transfer (out_valid & out_ready):
  - cnt increments.
  - Release occurs when last[sel]=1 or cnt==MAX_HOLD-1.
  - On release:
    - ptr=sel+1 (wraps 7→0).
    - Re-arbitrate in the same cycle using the current req with the new ptr, so the previous owner has lowest priority.
    - If a requester is found, stay BUSY with the new owner and clear cnt. Otherwise go to IDLE with grant=0.
- BUSY, req[sel]=0 (owner abandons): go to IDLE next cycle, ptr=sel+1, grant=0.
- BUSY, out_valid=1 and out_ready=0: hold everything; the stall is unbounded.
- Requests from non-owners never preempt the owner.
- A forced release at MAX_HOLD splits a packet. The requester re-competes for the remainder.
- In IDLE, sel holds its last value and grant=0.

## Timing
- Reset values: IDLE, grant=0, sel=0, ptr=0, cnt=0. Consequently out_valid=0, out_last=0, ack=0.
- Reset is asynchronous. Asserting it mid-packet drops the grant immediately, and the partial packet is lost.
- Grant latency: req rising in IDLE at cycle n gives grant at cycle n+1. The earliest ack is in cycle n+1.
- out_valid, out_last and ack are combinational from registered grant/sel and the live req/last/out_ready. There is no path from out_ready to state other than through the transfer condition.
- Back-to-back handoff has zero bubble: the new owner's first word can be acked in the cycle after the previous owner's final ack.
- Sustained throughput is one word per cycle when out_ready=1.

## Structure
- Shared package nt_bus_pkg holds:
  - N_PORTS=8 and SEL_W=3.
  - State encodings ST_IDLE=1'b0 and ST_BUSY=1'b1.
  - CNT_W=4.
- One sub-module, rr_pick8:
  - Combinational.
  - Inputs: req[7:0] and ptr[2:0].
  - Outputs: any, idx[2:0].
  - It is used for both the IDLE pick and the release re-arbitration.
- The FSM, counter and pointer live in mux8way16_arbiter.

## Test plan
- Reset held during BUSY (owner 5, cnt=2): reset asserts mid-cycle → grant=0 and out_valid=0 immediately. After release, req=8'h20 → grant=8'h20 one cycle later, ptr=0 behaviour.
- Single requester 3, two-word packet, out_ready=1, last on word 2 → grant=8'h08 for 2 cycles, ack[3] pulses 2×, out_last on cycle 2, then IDLE (grant=0).
- req=8'hFF constant, last=8'hFF, out_ready=1 → sel sequence 0,1,2,…,7,0 on consecutive cycles with no bubble, one ack per cycle.
- MAX_HOLD=4, requester 5 streams 6 words with last=0 while req[2]=1 → 4 acks to 5, then grant=8'h04 next cycle. After requester 2 finishes, requester 5 is regranted for its remaining 2 words.
- Owner 1 with out_ready=0 for 10 cycles while req=8'hFF → grant stays 8'h02, ack=0. out_ready=1 → ack[1] in that cycle.
- Owner 6 drops req mid-packet (cnt=1) → IDLE next cycle. Then with req=8'h41 → grant=8'h01, since the wrapped pointer is 7 and requester 0 precedes 6.
